parking_lot_controller: RTL and testbench
=========================================

// Module: parking_lot_controller
//
// PURPOSE
//   Sequences the 4-bit up/down occupancy counter for a single-lane lot gate.
//   Watches two beam sensors (a = outer, b = inner) and decodes complete car
//   entries and exits. Issues one-cycle enable+up / enable+down commands to the
//   counter and flags full, empty and illegal sensor sequences.
//   Sits between the gate sensor pins and the counter instance.
//
// PARAMETERS
//   WIDTH     4   width of the counter value fed back on count
//   CAPACITY  15  lot size; must be <= 2**WIDTH-1 so the counter never wraps
//
// PORTS
//   clk     in   1      system clock, rising edge
//   reset   in   1      asynchronous, active-high; clears all state
//   a       in   1      outer sensor, 1 = beam blocked; asynchronous to clk
//   b       in   1      inner sensor, 1 = beam blocked; asynchronous to clk
//   count   in   WIDTH  current occupancy from the counter output
//   up      out  1      count-up command to counter; registered
//   down    out  1      count-down command to counter; registered
//   enable  out  1      counter enable; registered; high only with up or down
//   full    out  1      count == CAPACITY; combinational from count
//   empty   out  1      count == 0; combinational from count
//   err     out  1      one-cycle pulse on a rejected or illegal sequence
//
// BEHAVIOUR
// - Reset: up = down = enable = err = 0, FSM = IDLE, synchronizer flops = 0.
//   Reset does not touch the counter.
// - Synchronization: a and b each pass through 2 flops (a_s, b_s). The FSM uses
//   only {a_s,b_s}.
// - Latency: a sensor change sampled at edge k is seen by the FSM at edge k+2.
//   up/down/enable rise after edge k+2 and fall after edge k+3.
// - Counter contract: the counter steps +1 on the edge where enable&up, and -1
//   on the edge where enable&down. The controller never asserts up and down
//   together. enable is never high without exactly one of up/down.
// - FSM, sampled {a_s,b_s}. Any value not listed for a state goes to RECOVER
//   with err pulsed.
//     IDLE : 00 stay; 10 -> EN1; 01 -> EX1; 11 -> RECOVER (err)
//     EN1  : 10 stay; 11 -> EN2; 00 -> IDLE (car backed out, no pulse)
//     EN2  : 11 stay; 01 -> EN3; 10 -> EN1
//     EN3  : 01 stay; 11 -> EN2;
//            00 -> IDLE with up+enable pulse if !full, else err pulse
//     EX1  : 01 stay; 11 -> EX2; 00 -> IDLE (no pulse)
//     EX2  : 11 stay; 10 -> EX3; 01 -> EX1
//     EX3  : 10 stay; 11 -> EX2;
//            00 -> IDLE with down+enable pulse if !empty, else err pulse
//     RECOVER : stay until 00, then -> IDLE; no pulses while here
// - Direct 2-bit jumps (00<->11, 10<->01) are illegal in every state except
//   IDLE 11 (handled above). They go to RECOVER with a single err pulse.
// - full/empty are evaluated on the cycle of the final 00 transition. A
//   rejected entry or exit never moves the counter.
// - err is a single-cycle pulse per event. It is never high together with
//   enable.
// - Reset mid-sequence: returns to IDLE immediately with outputs 0 and no
//   pulse. If sensors are still non-00 after reset, the FSM follows the table
//   above; for example 11 gives RECOVER plus err.
// - Consecutive cars: a new sequence may start on the cycle after the return
//   to IDLE. Each event takes at least 4 FSM cycles, so enable pulses are
//   never adjacent.
//
// TESTING
// 1. Reset with a=b=0, count=0: up=down=enable=err=0, empty=1, full=0.
// 2. Entry a,b = 10,11,01,00 (each held 3 cycles), count=3: exactly one
//    up+enable pulse, 3 edges after the final 00; count=4.
// 3. Exit a,b = 01,11,10,00, count=4: one down+enable pulse; count=3.
//    Partial entry 10,11,10,00: no pulse, no err.
// 4. Entry with count=15 (full=1): no enable, one err pulse.
//    Exit with count=0: no enable, one err pulse.
// 5. Illegal jump 00->11->00: err pulses once, FSM goes RECOVER then IDLE,
//    no enable. Glitch on a shorter than 1 cycle between edges: no effect.
// 6. Assert reset while in EN3 (a,b=01), then release: no pulse. The rest of
//    the entry (00) gives no pulse, and count is unchanged.

Source files
------------

// File: rtl/parking_lot_controller.sv
// Gate sequencer for a single-lane lot: decodes a/b beam sequences into one-cycle
// up/down counter commands and flags full, empty and illegal sequences.
module parking_lot_controller #(
  parameter int WIDTH    = 4,
  parameter int CAPACITY = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a,
  input  logic             b,
  input  logic [WIDTH-1:0] count,
  output logic             up,
  output logic             down,
  output logic             enable,
  output logic             full,
  output logic             empty,
  output logic             err
);

  typedef enum logic [2:0] {
    IDLE, EN1, EN2, EN3, EX1, EX2, EX3, RECOVER
  } state_t;

  state_t     state, state_next;
  logic       a_m, b_m, a_s, b_s;
  logic [1:0] ab;
  logic       up_n, down_n, enable_n, err_n, illegal;

  // Two-flop synchronizers; the sensors are asynchronous to clk.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_m <= 1'b0;
      b_m <= 1'b0;
      a_s <= 1'b0;
      b_s <= 1'b0;
    end else begin
      a_m <= a;
      b_m <= b;
      a_s <= a_m;
      b_s <= b_m;
    end
  end

  assign ab    = {a_s, b_s};
  assign full  = (count == WIDTH'(CAPACITY));
  assign empty = (count == '0);

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    up_n       = 1'b0;
    down_n     = 1'b0;
    enable_n   = 1'b0;
    err_n      = 1'b0;
    illegal    = 1'b0;
    case (state)
      IDLE: case (ab)
        2'b10:   state_next = EN1;
        2'b01:   state_next = EX1;
        2'b11:   illegal    = 1'b1;
        default: state_next = IDLE;
      endcase
      EN1: case (ab)
        2'b10:   state_next = EN1;
        2'b11:   state_next = EN2;
        2'b00:   state_next = IDLE;
        default: illegal    = 1'b1;
      endcase
      EN2: case (ab)
        2'b11:   state_next = EN2;
        2'b01:   state_next = EN3;
        2'b10:   state_next = EN1;
        default: illegal    = 1'b1;
      endcase
      EN3: case (ab)
        2'b01:   state_next = EN3;
        2'b11:   state_next = EN2;
        2'b00: begin
          state_next = IDLE;
          // A full lot rejects the entry without touching the counter.
          if (!full) begin
            up_n     = 1'b1;
            enable_n = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end
        default: illegal = 1'b1;
      endcase
      EX1: case (ab)
        2'b01:   state_next = EX1;
        2'b11:   state_next = EX2;
        2'b00:   state_next = IDLE;
        default: illegal    = 1'b1;
      endcase
      EX2: case (ab)
        2'b11:   state_next = EX2;
        2'b10:   state_next = EX3;
        2'b01:   state_next = EX1;
        default: illegal    = 1'b1;
      endcase
      EX3: case (ab)
        2'b10:   state_next = EX3;
        2'b11:   state_next = EX2;
        2'b00: begin
          state_next = IDLE;
          if (!empty) begin
            down_n   = 1'b1;
            enable_n = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end
        default: illegal = 1'b1;
      endcase
      RECOVER: if (ab == 2'b00) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (illegal) begin
      state_next = RECOVER;
      err_n      = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      up     <= 1'b0;
      down   <= 1'b0;
      enable <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_next;
      up     <= up_n;
      down   <= down_n;
      enable <= enable_n;
      err    <= err_n;
    end
  end

endmodule

// File: tb/tb_parking_lot_controller.sv
// Directed bench for parking_lot_controller: a behavioural counter closes the loop,
// and observed command/err events are matched against a queue of expected events.
module tb_parking_lot_controller;

  typedef enum int {EV_UP, EV_DOWN, EV_ERR} ev_t;
  typedef struct {
    ev_t kind;
    int  cyc;
  } ev_s;

  logic       clk = 1'b0;
  logic       reset;
  logic       a, b;
  logic [3:0] cnt;
  logic       up, down, enable, full, empty, err;

  logic       load_en;
  logic [3:0] load_val;
  int         cyc = 0;
  int         last_cyc = 0;
  int         checks = 0;
  int         errors = 0;
  ev_s        obs_q[$];
  ev_s        exp_q[$];

  parking_lot_controller #(.WIDTH(4), .CAPACITY(15)) dut (
    .clk    (clk),
    .reset  (reset),
    .a      (a),
    .b      (b),
    .count  (cnt),
    .up     (up),
    .down   (down),
    .enable (enable),
    .full   (full),
    .empty  (empty),
    .err    (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural occupancy counter driven by the controller's commands.
  always @(posedge clk) begin
    if (load_en)             cnt <= load_val;
    else if (enable && up)   cnt <= cnt + 4'd1;
    else if (enable && down) cnt <= cnt - 4'd1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Monitor: command-shape invariants plus event capture, away from the rising edge.
  always @(negedge clk) begin
    if (enable || up || down) check("cmd_shape", int'(enable && (up ^ down)), 1);
    if (err) check("err_excl_enable", int'(enable), 0);
    if (enable && up)   obs_q.push_back('{EV_UP, cyc});
    if (enable && down) obs_q.push_back('{EV_DOWN, cyc});
    if (err)            obs_q.push_back('{EV_ERR, cyc});
  end

  // Each sensor value is held for three cycles.
  task automatic step(input logic [1:0] ab);
    @(negedge clk);
    {a, b}   = ab;
    last_cyc = cyc;
    repeat (2) @(negedge clk);
  endtask

  // A value driven at cycle N reaches the registered outputs three edges later.
  task automatic expect_ev(input ev_t kind);
    exp_q.push_back('{kind, last_cyc + 3});
  endtask

  task automatic load_count(input logic [3:0] v);
    @(negedge clk);
    load_val = v;
    load_en  = 1'b1;
    @(negedge clk);
    load_en  = 1'b0;
  endtask

  task automatic check_events(input string tag);
    ev_s o, e;
    repeat (8) @(negedge clk);
    check({tag, ":events"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check({tag, ":kind"}, int'(o.kind), int'(e.kind));
      check({tag, ":cycle"}, o.cyc, e.cyc);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    reset    = 1'b1;
    a        = 1'b0;
    b        = 1'b0;
    load_en  = 1'b1;
    load_val = 4'd0;
    repeat (3) @(negedge clk);
    check("rst_up", int'(up), 0);
    check("rst_down", int'(down), 0);
    check("rst_enable", int'(enable), 0);
    check("rst_err", int'(err), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_full", int'(full), 0);
    reset   = 1'b0;
    load_en = 1'b0;
    check_events("idle");

    // Complete entry with three cars inside.
    load_count(4'd3);
    step(2'b10); step(2'b11); step(2'b01); step(2'b00);
    expect_ev(EV_UP);
    check_events("entry");
    check("entry_count", int'(cnt), 4);

    // Complete exit.
    step(2'b01); step(2'b11); step(2'b10); step(2'b00);
    expect_ev(EV_DOWN);
    check_events("exit");
    check("exit_count", int'(cnt), 3);

    // Car backs out halfway through an entry.
    step(2'b10); step(2'b11); step(2'b10); step(2'b00);
    check_events("partial");
    check("partial_count", int'(cnt), 3);

    // Entry into a full lot is rejected.
    load_count(4'd15);
    check("full_flag", int'(full), 1);
    step(2'b10); step(2'b11); step(2'b01); step(2'b00);
    expect_ev(EV_ERR);
    check_events("entry_full");
    check("entry_full_count", int'(cnt), 15);

    // Exit from an empty lot is rejected.
    load_count(4'd0);
    check("empty_flag", int'(empty), 1);
    step(2'b01); step(2'b11); step(2'b10); step(2'b00);
    expect_ev(EV_ERR);
    check_events("exit_empty");
    check("exit_empty_count", int'(cnt), 0);

    // Illegal 00->11->00 jump from IDLE.
    step(2'b11);
    expect_ev(EV_ERR);
    step(2'b00);
    check_events("jump_idle");

    // Glitch on a that falls entirely between rising edges.
    @(negedge clk);
    #1 a = 1'b1;
    #2 a = 1'b0;
    check_events("glitch");

    // Illegal 10->01 jump from EN1; 01 is held in RECOVER without further err.
    step(2'b10); step(2'b01);
    expect_ev(EV_ERR);
    step(2'b00);
    check_events("jump_en1");

    // The FSM is back in IDLE and accepts a normal entry.
    step(2'b10); step(2'b11); step(2'b01); step(2'b00);
    expect_ev(EV_UP);
    check_events("entry_after_recover");
    check("recover_count", int'(cnt), 1);

    // Reset while in EN3, then finish the entry: nothing counted.
    load_count(4'd5);
    step(2'b10); step(2'b11); step(2'b01);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_outputs", int'({up, down, enable, err}), 0);
    reset = 1'b0;
    step(2'b01);
    step(2'b00);
    check_events("mid_reset");
    check("mid_reset_count", int'(cnt), 5);

    // Sensors at 11 when reset releases: RECOVER with one err.
    @(negedge clk);
    reset = 1'b1;
    {a, b} = 2'b11;
    repeat (2) @(negedge clk);
    reset    = 1'b0;
    last_cyc = cyc;
    expect_ev(EV_ERR);
    repeat (4) @(negedge clk);
    step(2'b00);
    check_events("reset_11");
    check("reset_11_count", int'(cnt), 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
